// File: rtl/clk_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the clock-request controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } clk_ctrl_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One timer serves both WAKE and DRAIN, so it is sized for the longer wait.
    function automatic int timer_width(input int wake_cyc, input int idle_cyc);
        return $clog2(max_int(wake_cyc, idle_cyc) + 1);
    endfunction

    function automatic bit clk_ctrl_params_ok(input int nreq, input int wake_cyc, input int idle_cyc);
        return (wake_cyc >= 1) && (idle_cyc >= 1) && (nreq >= 1) && (nreq <= 16);
    endfunction

endpackage

// File: rtl/clk_ctrl_timer.sv
// Clearable up-counter with a terminal-count compare; done is high while the
// count equals the terminal value presented on tc.
module clk_ctrl_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done = (cnt_q == tc);

endmodule

// File: rtl/clk_req_ctrl.sv
// Sequences a shared clock-source enable for NREQ requesters: wake-up delay
// before the first grant, grants while requested, idle timeout before shutdown.
module clk_req_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic            clk_en,
    output logic [31:0]     on_cnt
);

    if (!clk_ctrl_params_ok(NREQ, WAKE_CYC, IDLE_CYC)) begin : g_param_err
        $error("clk_req_ctrl: NREQ must be 1..16, WAKE_CYC and IDLE_CYC >= 1");
    end

    localparam int          TW      = timer_width(WAKE_CYC, IDLE_CYC);
    localparam logic [TW-1:0] WAKE_TC = TW'(WAKE_CYC - 1);
    localparam logic [TW-1:0] IDLE_TC = TW'(IDLE_CYC - 1);

    clk_ctrl_state_t state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            clk_en_q, clk_en_d;
    logic [31:0]     on_cnt_q, on_cnt_d;
    logic            tmr_clr, tmr_inc, tmr_done;
    logic [TW-1:0]   tmr_tc;

    assign tmr_tc = (state_q == WAKE) ? WAKE_TC : IDLE_TC;

    clk_ctrl_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .tc   (tmr_tc),
        .done (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OFF;
            ack_q    <= '0;
            clk_en_q <= 1'b0;
            on_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            clk_en_q <= clk_en_d;
            on_cnt_q <= on_cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        unique case (state_q)
            OFF: begin
                if (|req) begin
                    state_d = WAKE;
                    tmr_clr = 1'b1;
                end
            end
            WAKE: begin
                // Wake-up always runs to completion, even if req is withdrawn.
                if (tmr_done) begin
                    state_d = ON;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ON: begin
                if (req == '0 && ack_q == '0) begin
                    state_d = DRAIN;
                    tmr_clr = 1'b1;
                end
            end
            DRAIN: begin
                // A new request beats an expiring idle timer.
                if (|req) begin
                    state_d = ON;
                    tmr_clr = 1'b1;
                end else if (tmr_done) begin
                    state_d = OFF;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    always_comb begin
        clk_en_d = (state_d != OFF);
        ack_d    = (state_q == ON) ? req : (ack_q & req);
        on_cnt_d = (clk_en_q && on_cnt_q != 32'hFFFF_FFFF) ? on_cnt_q + 32'd1 : on_cnt_q;
    end

    assign ack    = ack_q;
    assign clk_en = clk_en_q;
    assign on_cnt = on_cnt_q;

endmodule

// File: tb/tb_clk_req_ctrl.sv
// Directed scoreboard bench for clk_req_ctrl with default parameters
// (NREQ=4, WAKE_CYC=4, IDLE_CYC=6).
module tb_clk_req_ctrl;
    import clk_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  ack;
        logic        en;
        logic [31:0] on;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        clk_en;
    logic [31:0] on_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] exp_on  = '0;
    logic        last_en = 1'b0;

    clk_req_ctrl #(.NREQ(4), .WAKE_CYC(4), .IDLE_CYC(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack    (ack),
        .clk_en (clk_en),
        .on_cnt (on_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, queue the outputs expected after that edge,
    // then compare them 1 time unit past the edge.
    task automatic cycle(input logic rst_v, input logic [3:0] req_v,
                         input logic [3:0] ea, input logic ee, input string tag);
        exp_t e;
        rst = rst_v;
        req = req_v;
        if (rst_v) exp_on = '0;
        else if (last_en && exp_on != 32'hFFFF_FFFF) exp_on = exp_on + 32'd1;
        e.ack = ea;
        e.en  = rst_v ? 1'b0 : ee;
        e.on  = exp_on;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s.ack", tag), {28'd0, ack}, {28'd0, e.ack});
            check($sformatf("%s.clk_en", tag), {31'd0, clk_en}, {31'd0, e.en});
            check($sformatf("%s.on_cnt", tag), on_cnt, e.on);
            last_en = e.en;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset, then idle.
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        check("reset.state", {30'd0, dut.state_q}, {30'd0, OFF});
        repeat (20) cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "idle");

        // Single requester wake-up: clk_en after E0, ack after E5.
        repeat (5) cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "wake1");
        repeat (3) cycle(1'b0, 4'b0001, 4'b0001, 1'b1, "grant1");
        // Drop: ack falls this edge, then 1 edge into DRAIN + 6 idle.
        cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drop1");
        repeat (6) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drain1");
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "off1");
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "off1_hold");

        // Second requester joins during ON, then each leaves in turn.
        repeat (5) cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "wake2");
        cycle(1'b0, 4'b0001, 4'b0001, 1'b1, "grant2");
        repeat (2) cycle(1'b0, 4'b0101, 4'b0101, 1'b1, "join2");
        check("join2.state", {30'd0, dut.state_q}, {30'd0, ON});
        repeat (2) cycle(1'b0, 4'b0100, 4'b0100, 1'b1, "leave0");
        check("leave0.state", {30'd0, dut.state_q}, {30'd0, ON});
        cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "leave2");

        // req[1] raised at DRAIN idle count 3: back to ON, ack two edges later.
        repeat (4) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drain2");
        check("drain2.state", {30'd0, dut.state_q}, {30'd0, DRAIN});
        cycle(1'b0, 4'b0010, 4'b0000, 1'b1, "rewake");
        repeat (2) cycle(1'b0, 4'b0010, 4'b0010, 1'b1, "regrant");

        // req raised exactly on the idle-expiry edge keeps the clock on.
        cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drop3");
        repeat (6) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drain3");
        cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "expiry_req");
        check("expiry_req.state", {30'd0, dut.state_q}, {30'd0, ON});
        cycle(1'b0, 4'b0001, 4'b0001, 1'b1, "expiry_grant");
        cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drop4");
        repeat (6) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "drain4");
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "off4");

        // Request withdrawn during WAKE: WAKE completes, no ack, then shutdown.
        repeat (2) cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "pulse");
        repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "pulse_wake");
        check("pulse.state_on", {30'd0, dut.state_q}, {30'd0, ON});
        repeat (6) cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "pulse_drain");
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "pulse_off");

        // Reset mid-WAKE.
        repeat (2) cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "rst_wake");
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, "rst_mid_wake");
        check("rst_mid_wake.state", {30'd0, dut.state_q}, {30'd0, OFF});
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, "rst_mid_wake_idle");

        // Reset with all four grants held.
        repeat (5) cycle(1'b0, 4'b1111, 4'b0000, 1'b1, "all_wake");
        repeat (2) cycle(1'b0, 4'b1111, 4'b1111, 1'b1, "all_grant");
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, "rst_acks");
        check("rst_acks.state", {30'd0, dut.state_q}, {30'd0, OFF});

        // on_cnt saturation from a preloaded value near the top.
        cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "sat_wake");
        force dut.on_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.on_cnt_q;
        exp_on = 32'hFFFF_FFFD;
        repeat (4) cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "sat");
        repeat (2) cycle(1'b0, 4'b0001, 4'b0001, 1'b1, "sat_hold");

        check("scoreboard.empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
